// File: rtl/audio_codec_slave.sv
// audio_codec_slave
//   Codec-side end of the serial audio link, used as an on-chip codec emulator.
//   DAC direction: MSB-first, left-justified words on AUD_DACDAT are
//   deserialised and presented as dac_sample/dac_left with a dac_valid pulse.
//   ADC direction: host-staged words in two holding registers (left/right)
//   are serialised onto AUD_ADCDAT. adc_req reports each consumption.
//
//   Ports:
//     clk, reset        system clock, async active-high reset
//     AUD_BCLK          bit clock from master (async, each level >= 2 clk)
//     AUD_DACLRCK       frame clock, 1 = left
//     AUD_DACDAT        serial DAC data in
//     AUD_ADCDAT        serial ADC data out (registered)
//     dac_sample/left/valid   completed DAC word, its channel, 1-cycle pulse
//     adc_data/wr/wr_left     holding register write port
//     adc_req/adc_left        holding register consumed (pulse) and its channel
//     frame_err               LRCK edge arrived mid-word (pulse)
//     loopback                only with AUDIO_CODEC_SLAVE_LOOPBACK_EN defined:
//                             completed DAC words are written back into the
//                             holding register of the same channel.
//
//   Build option: `define AUDIO_CODEC_SLAVE_LOOPBACK_EN adds the loopback port.

module audio_codec_slave #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
`ifdef AUDIO_CODEC_SLAVE_LOOPBACK_EN
  input  logic             loopback,
`endif
  input  logic             AUD_BCLK,
  input  logic             AUD_DACLRCK,
  input  logic             AUD_DACDAT,
  output logic             AUD_ADCDAT,
  output logic [WIDTH-1:0] dac_sample,
  output logic             dac_left,
  output logic             dac_valid,
  input  logic [WIDTH-1:0] adc_data,
  input  logic             adc_wr,
  input  logic             adc_wr_left,
  output logic             adc_req,
  output logic             adc_left,
  output logic             frame_err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // Synchronisers: [1] is the synchronised value, [2] the edge-detect stage.
  logic [2:0] bclk_sync_q;
  logic [2:0] lrck_sync_q;
  logic [1:0] dat_sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bclk_sync_q <= '0;
      lrck_sync_q <= '0;
      dat_sync_q  <= '0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[1:0], AUD_BCLK};
      lrck_sync_q <= {lrck_sync_q[1:0], AUD_DACLRCK};
      dat_sync_q  <= {dat_sync_q[0], AUD_DACDAT};
    end
  end

  logic bclk_rise, lrck_edge, lrck_s, dat_s;
  assign bclk_rise = bclk_sync_q[1] & ~bclk_sync_q[2];
  assign lrck_edge = lrck_sync_q[1] ^ lrck_sync_q[2];
  assign lrck_s    = lrck_sync_q[1];
  assign dat_s     = dat_sync_q[1];

  logic lb_active;
`ifdef AUDIO_CODEC_SLAVE_LOOPBACK_EN
  assign lb_active = loopback;
`else
  assign lb_active = 1'b0;
`endif

  state_t                  state_q, state_d;
  logic                    ch_q, ch_d;
  logic [CW-1:0]           bitcnt_q, bitcnt_d;
  logic [WIDTH-1:0]        dac_sr_q, dac_sr_d;
  logic [WIDTH-1:0]        adc_sr_q, adc_sr_d;
  logic [1:0][WIDTH-1:0]   hold_q, hold_d;
  logic [WIDTH-1:0]        dac_sample_q, dac_sample_d;
  logic                    dac_left_q, dac_left_d;
  logic                    dac_valid_q, dac_valid_d;
  logic                    adc_req_q, adc_req_d;
  logic                    adc_left_q, adc_left_d;
  logic                    frame_err_q, frame_err_d;

  logic [WIDTH-1:0]        word;
  logic [WIDTH-1:0]        adc_next;

  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    bitcnt_d     = bitcnt_q;
    dac_sr_d     = dac_sr_q;
    adc_sr_d     = adc_sr_q;
    hold_d       = hold_q;
    dac_sample_d = dac_sample_q;
    dac_left_d   = dac_left_q;
    dac_valid_d  = 1'b0;
    adc_req_d    = 1'b0;
    adc_left_d   = adc_left_q;
    frame_err_d  = 1'b0;
    word         = {dac_sr_q[WIDTH-2:0], dat_s};
    adc_next     = adc_sr_q;

    // Host write. Consumption below reads hold_q, so a write landing on the
    // register being consumed this cycle only takes effect next frame.
    if (adc_wr) hold_d[adc_wr_left] = adc_data;

    if (lrck_edge) begin
      // LRCK edge wins over any coincident BCLK rise; that rise becomes bit 0.
      ch_d     = lrck_s;
      state_d  = SHIFT;
      bitcnt_d = '0;
      if (state_q == SHIFT && bitcnt_q != '0) frame_err_d = 1'b1;
      if (state_q != DONE) begin
        adc_next   = hold_q[lrck_s];
        adc_req_d  = 1'b1;
        adc_left_d = lrck_s;
      end
      if (bclk_rise) begin
        dac_sr_d = word;
        bitcnt_d = CW'(1);
        adc_next = {adc_next[WIDTH-2:0], 1'b0};
      end
      adc_sr_d = adc_next;
    end else if (state_q == SHIFT && bclk_rise) begin
      dac_sr_d = word;
      bitcnt_d = bitcnt_q + CW'(1);
      if (bitcnt_q == CW'(WIDTH - 1)) begin
        dac_sample_d = word;
        dac_left_d   = ch_q;
        dac_valid_d  = 1'b1;
        state_d      = DONE;
        // Preload the other channel now: the master samples its first bit
        // sooner after its LRCK edge than our synchronised edge detect.
        adc_sr_d     = hold_q[~ch_q];
        adc_req_d    = 1'b1;
        adc_left_d   = ~ch_q;
        if (lb_active) hold_d[ch_q] = word;
      end else begin
        adc_sr_d = {adc_sr_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ch_q         <= 1'b0;
      bitcnt_q     <= '0;
      dac_sr_q     <= '0;
      adc_sr_q     <= '0;
      hold_q       <= '0;
      dac_sample_q <= '0;
      dac_left_q   <= 1'b0;
      dac_valid_q  <= 1'b0;
      adc_req_q    <= 1'b0;
      adc_left_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      bitcnt_q     <= bitcnt_d;
      dac_sr_q     <= dac_sr_d;
      adc_sr_q     <= adc_sr_d;
      hold_q       <= hold_d;
      dac_sample_q <= dac_sample_d;
      dac_left_q   <= dac_left_d;
      dac_valid_q  <= dac_valid_d;
      adc_req_q    <= adc_req_d;
      adc_left_q   <= adc_left_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign AUD_ADCDAT = adc_sr_q[WIDTH-1];
  assign dac_sample = dac_sample_q;
  assign dac_left   = dac_left_q;
  assign dac_valid  = dac_valid_q;
  assign adc_req    = adc_req_q;
  assign adc_left   = adc_left_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_audio_codec_slave.sv
module tb_audio_codec_slave;
  localparam int W = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         aud_bclk, aud_lrck, aud_dacdat, aud_adcdat;
  logic [W-1:0] dac_sample, adc_data;
  logic         dac_left, dac_valid, adc_wr, adc_wr_left, adc_req, adc_left, frame_err;
`ifdef AUDIO_CODEC_SLAVE_LOOPBACK_EN
  logic         loopback;
`endif

  audio_codec_slave #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
`ifdef AUDIO_CODEC_SLAVE_LOOPBACK_EN
    .loopback(loopback),
`endif
    .AUD_BCLK(aud_bclk), .AUD_DACLRCK(aud_lrck), .AUD_DACDAT(aud_dacdat),
    .AUD_ADCDAT(aud_adcdat),
    .dac_sample(dac_sample), .dac_left(dac_left), .dac_valid(dac_valid),
    .adc_data(adc_data), .adc_wr(adc_wr), .adc_wr_left(adc_wr_left),
    .adc_req(adc_req), .adc_left(adc_left), .frame_err(frame_err)
  );

  int n_chk = 0;
  int n_fail = 0;
  int exp_ferr = 0;
  int got_ferr = 0;

  typedef struct packed { logic left; logic [W-1:0] data; } dac_exp_t;
  dac_exp_t dac_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every dac_valid, checks adc_req alternation.
  logic prev_left;
  bit   have_prev;
  always @(negedge clk) begin
    if (reset) begin
      have_prev = 1'b0;
    end else begin
      if (dac_valid) begin
        if (dac_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL dac_valid_unexpected: got left=%0b data=%h expected no word", dac_left, dac_sample);
        end else begin
          dac_exp_t e;
          e = dac_q.pop_front();
          check("dac_left", {31'd0, dac_left}, {31'd0, e.left});
          check("dac_sample", {16'd0, dac_sample}, {16'd0, e.data});
        end
      end
      if (frame_err) got_ferr++;
      if (adc_req) begin
        if (have_prev) check("adc_left_alternate", {31'd0, adc_left}, {31'd0, ~prev_left});
        prev_left = adc_left;
        have_prev = 1'b1;
      end
    end
  end

  // One BCLK period of the emulated master: data/LRCK change on the fall,
  // ADC bit sampled at the rise.
  task automatic bit_cyc(input logic lr, input logic d, output logic b);
    aud_bclk = 1'b0; aud_lrck = lr; aud_dacdat = d;
    repeat (6) @(negedge clk);
    aud_bclk = 1'b1; b = aud_adcdat;
    repeat (6) @(negedge clk);
  endtask

  task automatic frame(input logic [W-1:0] l, input logic [W-1:0] r, input int lbits,
                       input bit chk_adc, input logic [W-1:0] el, input logic [W-1:0] er);
    logic [W-1:0] gl, gr;
    logic b;
    gl = '0; gr = '0;
    if (lbits == W) dac_q.push_back({1'b1, l});
    else exp_ferr++;
    dac_q.push_back({1'b0, r});
    for (int i = 0; i < lbits; i++) begin
      bit_cyc(1'b1, l[W-1-i], b); gl[W-1-i] = b;
    end
    for (int i = 0; i < W; i++) begin
      bit_cyc(1'b0, r[W-1-i], b); gr[W-1-i] = b;
    end
    if (chk_adc) begin
      check("adc_rx_left", {16'd0, gl}, {16'd0, el});
      check("adc_rx_right", {16'd0, gr}, {16'd0, er});
    end
  endtask

  task automatic hold_wr(input logic left, input logic [W-1:0] d);
    @(negedge clk);
    adc_wr = 1'b1; adc_wr_left = left; adc_data = d;
    @(negedge clk);
    adc_wr = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_dac_sample"}, {16'd0, dac_sample}, 32'd0);
    check({tag, "_flags"}, {26'd0, dac_left, dac_valid, adc_req, adc_left, frame_err, aud_adcdat}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic b;
    reset = 1'b1;
    aud_bclk = 1'b0; aud_lrck = 1'b0; aud_dacdat = 1'b0;
    adc_data = '0; adc_wr = 1'b0; adc_wr_left = 1'b0;
`ifdef AUDIO_CODEC_SLAVE_LOOPBACK_EN
    loopback = 1'b0;
`endif
    repeat (3) @(negedge clk);
    #1 check_zero_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Basic traffic with staged ADC words.
    hold_wr(1'b1, 16'h8001);
    hold_wr(1'b0, 16'h7FFE);
    frame(16'hA5C3, 16'h0F0F, W, 1'b1, 16'h8001, 16'h7FFE);
    frame(16'h8000, 16'h0001, W, 1'b1, 16'h8001, 16'h7FFE);
    frame(16'hFFFF, 16'h0000, W, 1'b1, 16'h8001, 16'h7FFE);

    // Left holding refreshed between frames: the left word for the next
    // frame was already preloaded at the end of the previous right channel.
    hold_wr(1'b1, 16'h1234);
    frame(16'h1111, 16'h2222, W, 1'b1, 16'h8001, 16'h7FFE);
    frame(16'h3333, 16'h4444, W, 1'b1, 16'h1234, 16'h7FFE);
    frame(16'h5555, 16'h6666, W, 1'b1, 16'h1234, 16'h7FFE);

    // Short left channel: frame_err, left word dropped, right word intact.
    frame(16'hDEAD, 16'h5A5A, 9, 1'b0, '0, '0);
    frame(16'h1357, 16'h2468, W, 1'b1, 16'h1234, 16'h7FFE);

    // Async reset in the middle of a left word.
    for (int i = 0; i < 7; i++) bit_cyc(1'b1, 1'b1, b);
    @(negedge clk);
    reset = 1'b1;
    #1 check_zero_outputs("midreset");
    aud_lrck = 1'b0; aud_bclk = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    frame(16'hC0DE, 16'hBEEF, W, 1'b1, 16'h0000, 16'h0000);
    hold_wr(1'b1, 16'hA0A0);
    hold_wr(1'b0, 16'h0505);
    frame(16'h0FF0, 16'hF00F, W, 1'b0, '0, '0);
    frame(16'h7777, 16'h8888, W, 1'b1, 16'hA0A0, 16'h0505);

`ifdef AUDIO_CODEC_SLAVE_LOOPBACK_EN
    loopback = 1'b1;
    frame(16'h3C3C, 16'h4242, W, 1'b0, '0, '0);
    frame(16'h0000, 16'h0000, W, 1'b1, 16'h3C3C, 16'h4242);
    loopback = 1'b0;
`endif

    for (int i = 0; i < 2; i++) bit_cyc(1'b0, 1'b0, b);
    repeat (10) @(negedge clk);
    check("frame_err_count", got_ferr, exp_ferr);
    check("dac_words_outstanding", dac_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
